prio_scan_encoder: RTL and testbench

PRIO_SCAN_ENCODER -- requirements
Module: prio_scan_encoder

---
 rtl/prio_scan_pkg.sv | 14 +
 rtl/prio_enc_comb.sv | 25 ++
 rtl/prio_scan_encoder.sv | 96 +++++++++
 tb/tb_prio_scan_encoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_scan_pkg.sv
// Shared types and helpers for the priority scan encoder.
// The optional all-zero-vector beat is selected with PRIO_SCAN_EMPTY_BEAT_EN.
package prio_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic int idx_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational highest-set-bit finder; idx is 0 and any is 0 for an empty vector.
module prio_enc_comb
    import prio_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_scan_encoder.sv
// Captures a request vector and emits one beat per set bit, highest index first.
// Define PRIO_SCAN_EMPTY_BEAT_EN to report an all-zero vector as a single empty beat.
module prio_scan_encoder
    import prio_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_empty
);

    state_t           state;
    logic [WIDTH-1:0] pend;
    logic             valid_q;
    logic             alive_q;
    logic [IDX_W-1:0] top_idx;
    logic             any_set;
    logic             single;
    logic [WIDTH-1:0] bit_mask;
    logic             empty_q;

`ifndef PRIO_SCAN_EMPTY_BEAT_EN
    assign empty_q = 1'b0;
`endif

    prio_enc_comb #(.WIDTH(WIDTH)) u_enc (
        .vec (pend),
        .idx (top_idx),
        .any (any_set)
    );

    // Clearing the lowest set bit leaves zero exactly when one bit is set.
    assign single   = any_set && ((pend & (pend - WIDTH'(1))) == '0);
    assign bit_mask = WIDTH'(1) << top_idx;

    // alive_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = alive_q && (state == IDLE);
    assign out_valid = valid_q;
    assign out_idx   = top_idx;
    assign out_last  = valid_q && (single || empty_q);
    assign out_empty = empty_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pend    <= '0;
            valid_q <= 1'b0;
            alive_q <= 1'b0;
`ifdef PRIO_SCAN_EMPTY_BEAT_EN
            empty_q <= 1'b0;
`endif
        end else begin
            alive_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pend <= in_vec;
                        if (in_vec != '0) begin
                            state   <= SCAN;
                            valid_q <= 1'b1;
                        end
`ifdef PRIO_SCAN_EMPTY_BEAT_EN
                        else begin
                            state   <= SCAN;
                            valid_q <= 1'b1;
                            empty_q <= 1'b1;
                        end
`endif
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        pend <= pend & ~bit_mask;
                        if (out_last) begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
`ifdef PRIO_SCAN_EMPTY_BEAT_EN
                            empty_q <= 1'b0;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Self-checking bench for prio_scan_encoder (WIDTH=8 and WIDTH=16 instances).
module tb_prio_scan_encoder;

    logic       clk;
    logic       rst;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_empty;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] in_vec16;
    logic        out_valid16;
    logic        out_ready16;
    logic [3:0]  out_idx16;
    logic        out_last16;
    logic        out_empty16;

    int n_vec;
    int n_err;

    prio_scan_encoder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_empty (out_empty)
    );

    prio_scan_encoder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_vec    (in_vec16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_idx   (out_idx16),
        .out_last  (out_last16),
        .out_empty (out_empty16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] vec;
        logic       ordy;
        logic       e_rdy;
        logic       e_vld;
        int         e_idx;
        int         e_last;
        int         e_empty;
    } vec_t;

    typedef struct {
        int idx;
        int last;
        int empty;
    } beat_t;

    vec_t  tbl[$];
    beat_t q[$];

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [7:0] vec, input logic ordy,
                                input logic e_rdy, input logic e_vld, input int e_idx,
                                input int e_last, input int e_empty);
        vec_t r;
        r.iv = iv; r.vec = vec; r.ordy = ordy;
        r.e_rdy = e_rdy; r.e_vld = e_vld;
        r.e_idx = e_idx; r.e_last = e_last; r.e_empty = e_empty;
        return r;
    endfunction

    // Reference: one beat per set bit, descending; last flags the final one.
    task automatic push_vector(input logic [7:0] v);
        int k;
        int n;
        beat_t b;
        k = $countones(v);
        n = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                n++;
                b.idx = i; b.last = (n == k) ? 1 : 0; b.empty = 0;
                q.push_back(b);
            end
        end
`ifdef PRIO_SCAN_EMPTY_BEAT_EN
        if (k == 0) begin
            b.idx = 0; b.last = 1; b.empty = 1;
            q.push_back(b);
        end
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
        in_valid16 = 1'b0; in_vec16 = 16'h0000; out_ready16 = 1'b0;

        // Reset state
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_empty", int'(out_empty), 0);
        repeat (2) @(negedge clk);
        check("rst_hold_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        // Table: descending scan, backpressure hold, zero vector
        tbl.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 7, 0, 0));
        tbl.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 5, 0, 0));
        tbl.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 2, 0, 0));
        tbl.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 0, 1, 0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7, 1, 0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7, 1, 0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7, 1, 0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 7, 1, 0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0));
`ifdef PRIO_SCAN_EMPTY_BEAT_EN
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1, 1));
`else
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0));
`endif
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            in_valid = tbl[i].iv; in_vec = tbl[i].vec; out_ready = tbl[i].ordy;
            #1;
            check($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                check($sformatf("tbl%0d_out_idx", i), int'(out_idx), tbl[i].e_idx);
                check($sformatf("tbl%0d_out_last", i), int'(out_last), tbl[i].e_last);
                check($sformatf("tbl%0d_out_empty", i), int'(out_empty), tbl[i].e_empty);
            end
        end

        // Reset in the middle of an 8'hFF scan
        @(negedge clk);
        in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
        #1;
        check("mid_rst_accept", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mid_rst_beat0_idx", int'(out_idx), 7);
        @(negedge clk);
        #1;
        check("mid_rst_beat1_idx", int'(out_idx), 6);
        @(negedge clk);
        #1;
        check("mid_rst_beat2_valid", int'(out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_out_idx", int'(out_idx), 0);
        check("mid_rst_out_last", int'(out_last), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("after_rst%0d_in_ready", c), int'(in_ready), 1);
            check($sformatf("after_rst%0d_out_valid", c), int'(out_valid), 0);
        end

        // WIDTH=16: input changes during the scan must not matter
        @(negedge clk);
        in_valid16 = 1'b1; in_vec16 = 16'h8001; out_ready16 = 1'b1;
        #1;
        check("w16_accept", int'(in_ready16), 1);
        @(negedge clk);
        in_vec16 = 16'hFFFF;
        #1;
        check("w16_b0_valid", int'(out_valid16), 1);
        check("w16_b0_idx", int'(out_idx16), 15);
        check("w16_b0_last", int'(out_last16), 0);
        check("w16_b0_in_ready", int'(in_ready16), 0);
        @(negedge clk);
        #1;
        check("w16_b1_valid", int'(out_valid16), 1);
        check("w16_b1_idx", int'(out_idx16), 0);
        check("w16_b1_last", int'(out_last16), 1);
        @(negedge clk);
        in_valid16 = 1'b0;
        #1;
        check("w16_done_in_ready", int'(in_ready16), 1);
        check("w16_done_valid", int'(out_valid16), 0);

        // Randomized traffic against the beat-queue reference
        q.delete();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_vec = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            check("rnd_in_ready", int'(in_ready), (q.size() == 0) ? 1 : 0);
            check("rnd_out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
            if (q.size() != 0) begin
                check("rnd_out_idx", int'(out_idx), q[0].idx);
                check("rnd_out_last", int'(out_last), q[0].last);
                check("rnd_out_empty", int'(out_empty), q[0].empty);
                if (out_ready) void'(q.pop_front());
            end else if (in_valid) begin
                push_vector(in_vec);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
